// File: rtl/mmio_periph_bus_pkg.sv
// Shared definitions for the memory-mapped peripheral bus: data-memory op codes,
// I/O register offsets, timer control bit positions and the store lane-mask helper.
package mmio_periph_bus_pkg;

    // Stores reuse the load codes: BS/BZ store a byte, HS/HZ store a halfword.
    typedef enum logic [2:0] {
        DM_WD = 3'd0,
        DM_BS = 3'd1,
        DM_BZ = 3'd2,
        DM_HS = 3'd3,
        DM_HZ = 3'd4
    } dm_op_e;

    localparam logic [11:0] IO_BASE_DEF = 12'hbf8;

    localparam logic [7:0] IO_LED        = 8'h00;
    localparam logic [7:0] IO_SW         = 8'h04;
    localparam logic [7:0] IO_BTN        = 8'h08;
    localparam logic [7:0] IO_SEG_EN     = 8'h0C;
    localparam logic [7:0] IO_SEG_DIGITS = 8'h10;
    localparam logic [7:0] IO_KEYPAD     = 8'h14;
    localparam logic [7:0] IO_TCTRL      = 8'h18;
    localparam logic [7:0] IO_TCMP       = 8'h1C;
    localparam logic [7:0] IO_TCOUNT     = 8'h20;
    localparam logic [7:0] IO_TSTAT      = 8'h24;

    localparam int TCTRL_EN     = 0;
    localparam int TCTRL_AUTORL = 1;
    localparam int TCTRL_IRQ_EN = 2;

    // Bit 3 of the mask is byte offset 0, i.e. data bits [31:24] (big-endian).
    function automatic logic [3:0] lane_mask(input logic [2:0] op, input logic [1:0] off);
        logic [3:0] m;
        m = 4'b0000;
        case (op)
            DM_WD:        m = 4'b1111;
            DM_BS, DM_BZ: m = 4'b1000 >> off;
            DM_HS, DM_HZ: m = off[1] ? 4'b0011 : 4'b1100;
            default:      m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mmio_periph_bus_timer.sv
// Compare-match timer: free-running up-counter with match flag, optional
// autoreload and a registered level interrupt.
module periph_timer
    import mmio_periph_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_we,
    input  logic        cmp_we,
    input  logic        count_we,
    input  logic        stat_we,
    input  logic [31:0] wdata,
    output logic [2:0]  ctrl,
    output logic [31:0] cmp,
    output logic [31:0] count,
    output logic        match,
    output logic        irq
);

    logic hit;

    always_comb begin
        hit = ctrl[TCTRL_EN] && (count == cmp);
    end

    // CPU writes to CTRL/COUNT take priority over the hardware update;
    // a match set wins over a simultaneous write-1-to-clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl  <= '0;
            cmp   <= '0;
            count <= '0;
            match <= 1'b0;
            irq   <= 1'b0;
        end else begin
            if (cmp_we)
                cmp <= wdata;

            if (ctrl_we)
                ctrl <= wdata[2:0];
            else if (hit && !ctrl[TCTRL_AUTORL])
                ctrl[TCTRL_EN] <= 1'b0;

            if (count_we)
                count <= wdata;
            else if (hit) begin
                if (ctrl[TCTRL_AUTORL])
                    count <= '0;
            end else if (ctrl[TCTRL_EN])
                count <= count + 32'd1;

            if (hit)
                match <= 1'b1;
            else if (stat_we && wdata[0])
                match <= 1'b0;

            irq <= match & ctrl[TCTRL_IRQ_EN];
        end
    end

endmodule

// File: rtl/mmio_periph_bus.sv
// Memory-mapped slave: data RAM, GPIO/seven-seg registers and an optional timer
// (present when PERIPH_TIMER_EN is defined). One-cycle registered response.
module mmio_periph_bus
    import mmio_periph_bus_pkg::*;
#(
    parameter int          MEM_WORDS = 256,
    parameter int          N_LED     = 16,
    parameter int          N_SW      = 16,
    parameter int          N_PB      = 5,
    parameter logic [11:0] IO_BASE   = IO_BASE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             we,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic [2:0]       dm_op,
    output logic             ack,
    output logic             err,
    output logic [31:0]      rdata,
    output logic [N_LED-1:0] io_led,
    input  logic [N_SW-1:0]  io_switch,
    input  logic [N_PB-1:0]  io_btn,
    input  logic [3:0]       io_keypad,
    output logic [5:0]       seg_en,
    output logic [23:0]      seg_digits,
    output logic             irq
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [31:0]     mem [MEM_WORDS];
    logic [IDX_W-1:0] idx;
    logic [7:0]      off;
    logic            is_io, is_word, is_half, op_ok, mapped, ro, fault;
    logic            io_wr, ram_wr;
    logic [3:0]      lanes;
    logic [31:0]     st_data, ram_word, ram_load, io_rd, rd_next;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [1:0]      byte_sh;

    logic [N_SW-1:0] sw_s1, sw_s2;
    logic [N_PB-1:0] btn_s1, btn_s2;
    logic [3:0]      key_s1, key_s2;

    logic [2:0]      tmr_ctrl;
    logic [31:0]     tmr_cmp, tmr_count;
    logic            tmr_match;

    logic unused_bits;
    assign unused_bits = ^{addr, wdata};

    always_comb begin
        idx     = addr[IDX_W+1:2];
        off     = addr[7:0];
        is_io   = (addr[31:20] == IO_BASE);
        is_word = (dm_op == DM_WD);
        is_half = (dm_op == DM_HS) || (dm_op == DM_HZ);
        op_ok   = (dm_op <= DM_HZ);

        mapped = 1'b1;
        ro     = 1'b0;
        case (off)
            IO_LED, IO_SEG_EN, IO_SEG_DIGITS,
            IO_TCTRL, IO_TCMP, IO_TCOUNT, IO_TSTAT: mapped = 1'b1;
            IO_SW, IO_BTN, IO_KEYPAD:               ro = 1'b1;
            default:                                mapped = 1'b0;
        endcase

        fault = !op_ok
              || (is_half && addr[0])
              || (is_word && (addr[1:0] != 2'b00))
              || (is_io && (!is_word || !mapped || (we && ro)));

        io_wr  = req && we && is_io && !fault;
        ram_wr = req && we && !is_io && !fault;
    end

    // Store data replicated across lanes; the lane mask picks the target bytes.
    always_comb begin
        lanes = lane_mask(dm_op, addr[1:0]);
        if (is_word)
            st_data = wdata;
        else if (is_half)
            st_data = {2{wdata[15:0]}};
        else
            st_data = {4{wdata[7:0]}};
    end

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes[i])
                    mem[idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        ram_word = mem[idx];
        byte_sh  = ~addr[1:0];
        byte_sel = ram_word[{byte_sh, 3'b000} +: 8];
        half_sel = addr[1] ? ram_word[15:0] : ram_word[31:16];
        case (dm_op)
            DM_BS:   ram_load = {{24{byte_sel[7]}}, byte_sel};
            DM_BZ:   ram_load = {24'd0, byte_sel};
            DM_HS:   ram_load = {{16{half_sel[15]}}, half_sel};
            DM_HZ:   ram_load = {16'd0, half_sel};
            default: ram_load = ram_word;
        endcase
    end

    always_comb begin
        io_rd = '0;
        case (off)
            IO_LED:        io_rd = 32'(io_led);
            IO_SW:         io_rd = 32'(sw_s2);
            IO_BTN:        io_rd = 32'(btn_s2);
            IO_SEG_EN:     io_rd = {26'd0, seg_en};
            IO_SEG_DIGITS: io_rd = {8'd0, seg_digits};
            IO_KEYPAD:     io_rd = {28'd0, key_s2};
            IO_TCTRL:      io_rd = {29'd0, tmr_ctrl};
            IO_TCMP:       io_rd = tmr_cmp;
            IO_TCOUNT:     io_rd = tmr_count;
            IO_TSTAT:      io_rd = {31'd0, tmr_match};
            default:       io_rd = '0;
        endcase
        rd_next = is_io ? io_rd : ram_load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack        <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
            io_led     <= '0;
            seg_en     <= 6'h3f;
            seg_digits <= '0;
            sw_s1      <= '0;
            sw_s2      <= '0;
            btn_s1     <= '0;
            btn_s2     <= '0;
            key_s1     <= '0;
            key_s2     <= '0;
        end else begin
            sw_s1  <= io_switch;
            sw_s2  <= sw_s1;
            btn_s1 <= io_btn;
            btn_s2 <= btn_s1;
            key_s1 <= io_keypad;
            key_s2 <= key_s1;

            ack <= req;
            err <= req && fault;
            if (req) begin
                if (fault)
                    rdata <= '0;
                else if (!we)
                    rdata <= rd_next;
            end

            if (io_wr) begin
                case (off)
                    IO_LED:        io_led     <= wdata[N_LED-1:0];
                    IO_SEG_EN:     seg_en     <= wdata[5:0];
                    IO_SEG_DIGITS: seg_digits <= wdata[23:0];
                    default:       ;
                endcase
            end
        end
    end

`ifdef PERIPH_TIMER_EN
    periph_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .ctrl_we  (io_wr && (off == IO_TCTRL)),
        .cmp_we   (io_wr && (off == IO_TCMP)),
        .count_we (io_wr && (off == IO_TCOUNT)),
        .stat_we  (io_wr && (off == IO_TSTAT)),
        .wdata    (wdata),
        .ctrl     (tmr_ctrl),
        .cmp      (tmr_cmp),
        .count    (tmr_count),
        .match    (tmr_match),
        .irq      (irq)
    );
`else
    // Timer offsets stay mapped: reads return 0, writes are accepted and dropped.
    assign tmr_ctrl  = '0;
    assign tmr_cmp   = '0;
    assign tmr_count = '0;
    assign tmr_match = 1'b0;
    assign irq       = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_periph_bus.sv
// Self-checking bench for mmio_periph_bus: directed scenarios plus randomized RAM
// traffic against a byte-array big-endian memory model.
module tb_mmio_periph_bus;

    localparam logic [2:0] WD = 3'd0, BS = 3'd1, BZ = 3'd2, HS = 3'd3, HZ = 3'd4;
    localparam logic [31:0] IO = 32'hbf80_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  dm_op = '0;
    logic        ack, err, irq;
    logic [31:0] rdata;
    logic [15:0] io_led;
    logic [15:0] io_switch = '0;
    logic [4:0]  io_btn = '0;
    logic [3:0]  io_keypad = '0;
    logic [5:0]  seg_en;
    logic [23:0] seg_digits;

    int checks = 0;
    int failures = 0;

    logic        r_ack, r_err;
    logic [31:0] r_rd;
    logic [7:0]  mb [1024];

    mmio_periph_bus dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .dm_op(dm_op), .ack(ack), .err(err), .rdata(rdata), .io_led(io_led),
        .io_switch(io_switch), .io_btn(io_btn), .io_keypad(io_keypad),
        .seg_en(seg_en), .seg_digits(seg_digits), .irq(irq)
    );

    always #5 clk = ~clk;

    // One request per call; consecutive calls issue back-to-back requests.
    task automatic acc(input logic w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; we = w; dm_op = op; addr = a; wdata = d;
        @(posedge clk);
        #1;
        r_ack = ack; r_err = err; r_rd = rdata;
        req = 1'b0;
    endtask

    function automatic logic [31:0] model_load(input int a, input logic [2:0] op);
        case (op)
            BS:      return {{24{mb[a][7]}}, mb[a]};
            BZ:      return {24'd0, mb[a]};
            HS:      return {{16{mb[a][7]}}, mb[a], mb[a+1]};
            HZ:      return {16'd0, mb[a], mb[a+1]};
            default: return {mb[a], mb[a+1], mb[a+2], mb[a+3]};
        endcase
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        checks++; if (io_led !== 16'd0) begin failures++; $display("FAIL reset_led got=%h exp=0", io_led); end
        checks++; if (seg_en !== 6'h3f) begin failures++; $display("FAIL reset_seg_en got=%h exp=3f", seg_en); end
        checks++; if (seg_digits !== 24'd0) begin failures++; $display("FAIL reset_seg_digits got=%h exp=0", seg_digits); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ram_lanes;
        acc(1'b1, WD, 32'h10, 32'h11223344);
        checks++; if (r_ack !== 1'b1 || r_err !== 1'b0) begin failures++; $display("FAIL sw_ack got=%b/%b exp=1/0", r_ack, r_err); end
        acc(1'b1, BS, 32'h13, 32'h000000AA);
        checks++; if (r_ack !== 1'b1) begin failures++; $display("FAIL sb_ack got=%b exp=1", r_ack); end
        acc(1'b0, WD, 32'h10, 32'h0);
        checks++; if (r_rd !== 32'h112233AA || r_ack !== 1'b1) begin failures++; $display("FAIL lw_after_sb got=%h exp=112233aa", r_rd); end
        @(posedge clk); #1;
        checks++; if (ack !== 1'b0 || rdata !== 32'h112233AA) begin failures++; $display("FAIL idle_hold got=%b/%h exp=0/112233aa", ack, rdata); end
        acc(1'b0, BS, 32'h10, 32'h0);
        checks++; if (r_rd !== 32'h00000011) begin failures++; $display("FAIL lb_pos got=%h exp=00000011", r_rd); end
        acc(1'b1, BZ, 32'h10, 32'h00000080);
        acc(1'b0, BS, 32'h10, 32'h0);
        checks++; if (r_rd !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_sign got=%h exp=ffffff80", r_rd); end
        acc(1'b0, BZ, 32'h10, 32'h0);
        checks++; if (r_rd !== 32'h00000080) begin failures++; $display("FAIL lbu_zero got=%h exp=00000080", r_rd); end
        acc(1'b1, HS, 32'h12, 32'h0000BEEF);
        acc(1'b0, HZ, 32'h12, 32'h0);
        checks++; if (r_rd !== 32'h0000BEEF) begin failures++; $display("FAIL lhu_low got=%h exp=0000beef", r_rd); end
        acc(1'b0, HS, 32'h10, 32'h0);
        checks++; if (r_rd !== 32'hFFFF8022) begin failures++; $display("FAIL lh_high got=%h exp=ffff8022", r_rd); end
    endtask

    task automatic test_faults;
        acc(1'b1, HS, 32'h11, 32'h0000FFFF);
        checks++; if (r_err !== 1'b1 || r_rd !== 32'd0) begin failures++; $display("FAIL sh_misalign got=%b/%h exp=1/0", r_err, r_rd); end
        acc(1'b0, WD, 32'h10, 32'h0);
        checks++; if (r_rd !== 32'h8022BEEF || r_err !== 1'b0) begin failures++; $display("FAIL ram_unchanged got=%h exp=8022beef", r_rd); end
        acc(1'b1, WD, IO | 32'h04, 32'h1234);
        checks++; if (r_err !== 1'b1) begin failures++; $display("FAIL ro_write got=%b exp=1", r_err); end
        acc(1'b0, WD, IO | 32'hFC, 32'h0);
        checks++; if (r_err !== 1'b1 || r_rd !== 32'd0) begin failures++; $display("FAIL unmapped got=%b/%h exp=1/0", r_err, r_rd); end
        acc(1'b0, 3'd6, 32'h10, 32'h0);
        checks++; if (r_err !== 1'b1 || r_rd !== 32'd0) begin failures++; $display("FAIL bad_op got=%b/%h exp=1/0", r_err, r_rd); end
        acc(1'b1, BZ, IO | 32'h00, 32'hFF);
        checks++; if (r_err !== 1'b1 || io_led !== 16'd0) begin failures++; $display("FAIL io_byte got=%b/%h exp=1/0", r_err, io_led); end
        acc(1'b0, WD, 32'h12, 32'h0);
        checks++; if (r_err !== 1'b1) begin failures++; $display("FAIL lw_misalign got=%b exp=1", r_err); end
    endtask

    task automatic test_gpio;
        logic [15:0] sw;
        logic [4:0]  pb;
        logic [3:0]  kp;
        sw = 16'h00A5;
        io_switch = sw;
        repeat (3) @(posedge clk);
        acc(1'b0, WD, IO | 32'h04, 32'h0);
        checks++; if (r_rd !== 32'h000000A5 || r_err !== 1'b0) begin failures++; $display("FAIL sw_read got=%h exp=000000a5", r_rd); end
        for (int i = 0; i < 3; i++) begin
            sw = 16'($urandom); pb = 5'($urandom); kp = 4'($urandom);
            io_switch = sw; io_btn = pb; io_keypad = kp;
            repeat (3) @(posedge clk);
            acc(1'b0, WD, IO | 32'h04, 32'h0);
            checks++; if (r_rd !== {16'd0, sw}) begin failures++; $display("FAIL sw_rand got=%h exp=%h", r_rd, {16'd0, sw}); end
            acc(1'b0, WD, IO | 32'h08, 32'h0);
            checks++; if (r_rd !== {27'd0, pb}) begin failures++; $display("FAIL btn_rand got=%h exp=%h", r_rd, {27'd0, pb}); end
            acc(1'b0, WD, IO | 32'h14, 32'h0);
            checks++; if (r_rd !== {28'd0, kp}) begin failures++; $display("FAIL key_rand got=%h exp=%h", r_rd, {28'd0, kp}); end
        end
        acc(1'b1, WD, IO | 32'h00, 32'h3);
        checks++; if (io_led !== 16'h0003 || r_err !== 1'b0) begin failures++; $display("FAIL led_write got=%h exp=0003", io_led); end
        acc(1'b0, WD, IO | 32'h00, 32'h0);
        checks++; if (r_rd !== 32'h3) begin failures++; $display("FAIL led_read got=%h exp=3", r_rd); end
        acc(1'b1, WD, IO | 32'h0C, 32'h15);
        acc(1'b1, WD, IO | 32'h10, 32'h00987654);
        checks++; if (seg_en !== 6'h15 || seg_digits !== 24'h987654) begin failures++; $display("FAIL seg_write got=%h/%h exp=15/987654", seg_en, seg_digits); end
        acc(1'b0, WD, IO | 32'h10, 32'h0);
        checks++; if (r_rd !== 32'h00987654) begin failures++; $display("FAIL seg_read got=%h exp=00987654", r_rd); end
    endtask

`ifdef PERIPH_TIMER_EN
    task automatic test_timer;
        int n;
        acc(1'b1, WD, IO | 32'h1C, 32'd5);
        acc(1'b1, WD, IO | 32'h20, 32'd0);
        acc(1'b1, WD, IO | 32'h18, 32'd7);
        n = 0;
        while (irq !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        checks++; if (n != 7) begin failures++; $display("FAIL timer_irq_latency got=%0d exp=7", n); end
        acc(1'b0, WD, IO | 32'h20, 32'h0);
        checks++; if (r_rd !== 32'd1) begin failures++; $display("FAIL tcount_reload got=%h exp=1", r_rd); end
        acc(1'b1, WD, IO | 32'h24, 32'h1);
        acc(1'b0, WD, IO | 32'h24, 32'h0);
        checks++; if (r_rd !== 32'd0) begin failures++; $display("FAIL w1c_clear got=%h exp=0", r_rd); end
        acc(1'b0, WD, IO | 32'h24, 32'h0);
        acc(1'b1, WD, IO | 32'h24, 32'h1);
        acc(1'b0, WD, IO | 32'h24, 32'h0);
        checks++; if (r_rd !== 32'd1) begin failures++; $display("FAIL w1c_set_wins got=%h exp=1", r_rd); end
        acc(1'b1, WD, IO | 32'h18, 32'd0);
        acc(1'b1, WD, IO | 32'h24, 32'h1);
        repeat (2) @(posedge clk); #1;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", irq); end
        acc(1'b1, WD, IO | 32'h1C, 32'd2);
        acc(1'b1, WD, IO | 32'h20, 32'd0);
        acc(1'b1, WD, IO | 32'h18, 32'd1);
        repeat (10) @(posedge clk);
        acc(1'b0, WD, IO | 32'h18, 32'h0);
        checks++; if (r_rd !== 32'd0) begin failures++; $display("FAIL oneshot_en got=%h exp=0", r_rd); end
        acc(1'b0, WD, IO | 32'h20, 32'h0);
        checks++; if (r_rd !== 32'd2) begin failures++; $display("FAIL oneshot_hold got=%h exp=2", r_rd); end
        acc(1'b0, WD, IO | 32'h24, 32'h0);
        checks++; if (r_rd !== 32'd1 || irq !== 1'b0) begin failures++; $display("FAIL oneshot_stat got=%h/%b exp=1/0", r_rd, irq); end
        acc(1'b1, WD, IO | 32'h24, 32'h1);
    endtask
`else
    task automatic test_timer;
        acc(1'b1, WD, IO | 32'h18, 32'd7);
        checks++; if (r_err !== 1'b0) begin failures++; $display("FAIL notimer_write got=%b exp=0", r_err); end
        for (int o = 'h18; o <= 'h24; o += 4) begin
            acc(1'b0, WD, IO | 32'(o), 32'h0);
            checks++; if (r_rd !== 32'd0 || r_err !== 1'b0) begin failures++; $display("FAIL notimer_read_%0h got=%h exp=0", o, r_rd); end
        end
        repeat (10) @(posedge clk); #1;
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL notimer_irq got=%b exp=0", irq); end
    endtask
`endif

    task automatic test_random;
        logic [31:0] v, d, exp_rd;
        logic [2:0]  op;
        logic        w, exp_err;
        int          a;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            acc(1'b1, WD, 32'(i * 4), v);
            {mb[4*i], mb[4*i+1], mb[4*i+2], mb[4*i+3]} = v;
        end
        for (int i = 0; i < 400; i++) begin
            a  = int'($urandom_range(0, 1023));
            op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            w  = 1'($urandom);
            d  = $urandom;
            if (op > HZ) exp_err = 1'b1;
            else if ((op == HS || op == HZ) && a[0]) exp_err = 1'b1;
            else if (op == WD && a[1:0] != 2'b00) exp_err = 1'b1;
            else exp_err = 1'b0;
            exp_rd = exp_err ? 32'd0 : model_load(a, op);
            acc(w, op, 32'(a), d);
            checks++;
            if (r_ack !== 1'b1 || r_err !== exp_err || ((exp_err || !w) && r_rd !== exp_rd)) begin
                failures++;
                $display("FAIL rand_%0d a=%h op=%0d we=%b got=%b/%b/%h exp=1/%b/%h", i, a, op, w, r_ack, r_err, r_rd, exp_err, exp_rd);
            end
            if (w && !exp_err) begin
                if (op == WD) {mb[a], mb[a+1], mb[a+2], mb[a+3]} = d;
                else if (op == HS || op == HZ) {mb[a], mb[a+1]} = d[15:0];
                else mb[a] = d[7:0];
            end
        end
    endtask

    task automatic test_back_to_back_reset;
        acc(1'b1, WD, 32'h10, 32'hDEADBEEF);
        {mb[16], mb[17], mb[18], mb[19]} = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            acc(1'b0, WD, 32'h10, 32'h0);
            checks++; if (r_rd !== 32'hDEADBEEF || r_ack !== 1'b1) begin failures++; $display("FAIL b2b_%0d got=%b/%h exp=1/deadbeef", i, r_ack, r_rd); end
        end
        @(negedge clk);
        req = 1'b1; we = 1'b0; dm_op = WD; addr = 32'h20;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++; if (ack !== 1'b0 || rdata !== 32'd0 || err !== 1'b0) begin failures++; $display("FAIL async_reset got=%b/%h exp=0/0", ack, rdata); end
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        acc(1'b0, WD, 32'h10, 32'h0);
        checks++; if (r_rd !== 32'hDEADBEEF) begin failures++; $display("FAIL ram_retained got=%h exp=deadbeef", r_rd); end
        acc(1'b0, WD, 32'h3FC, 32'h0);
        checks++; if (r_rd !== model_load(32'h3FC, WD)) begin failures++; $display("FAIL ram_retained_top got=%h exp=%h", r_rd, model_load(32'h3FC, WD)); end
    endtask

    initial begin
        test_reset;
        test_ram_lanes;
        test_faults;
        test_gpio;
        test_timer;
        test_random;
        test_back_to_back_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
